// File: rtl/exc_irq_ctrl_pkg.sv
// Shared types and cause codes for the LEGv8 exception/interrupt controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  localparam logic [3:0] ES_NONE     = 4'b0000;
  localparam logic [3:0] ES_INVALID  = 4'b0010;
  localparam logic [3:0] ES_DBLFAULT = 4'b0011;
  localparam logic [3:0] ES_IRQ_BASE = 4'b1000;

  // Channel index is at most 3 bits because N_IRQ never exceeds 8.
  function automatic logic [3:0] irq_code(input logic [2:0] idx);
    return ES_IRQ_BASE | {1'b0, idx};
  endfunction

endpackage

// File: rtl/exc_irq_ctrl_if.sv
// Signal bundle between the datapath/decoder side and the exception controller.
interface exc_irq_ctrl_if
  import exc_pkg::*;
#(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4
) ();

  // Handshake: Exc is a held request; the datapath accepts it by raising
  // ExcAck while Exc=1 (ExcAck with Exc=0 is ignored). Exc drops the cycle
  // after acceptance, and ERet ends the handler that the acceptance opened.
  logic [N_IRQ-1:0]     ExtIRQ;
  logic [N_IRQ-1:0]     IrqMask;
  logic                 NotAnInstr;
  logic                 ERet;
  logic                 ExcAck;
  logic                 Exc;
  logic [ESTATUS_W-1:0] EStatus;
  logic [N_IRQ-1:0]     ExtIAck;
  logic                 InHandler;
  logic [N_IRQ-1:0]     Pending;
  state_e               state_dbg;

  modport master (
    output ExtIRQ, IrqMask, NotAnInstr, ERet, ExcAck,
    input  Exc, EStatus, ExtIAck, InHandler, Pending, state_dbg
  );

  modport slave (
    input  ExtIRQ, IrqMask, NotAnInstr, ERet, ExcAck,
    output Exc, EStatus, ExtIAck, InHandler, Pending, state_dbg
  );

endinterface

// File: rtl/irq_pending.sv
// Per-channel rising-edge detector with sticky pending bits.
module irq_pending #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ext_irq,
  input  logic [N_IRQ-1:0] clr,
  output logic [N_IRQ-1:0] pending
);

  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] rise;

  // A fresh edge in the clearing cycle wins so that request is not lost.
  always_comb begin
    rise       = ext_irq & ~irq_prev_q;
    irq_prev_d = ext_irq;
    pending_d  = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: prioritises invalid-opcode and masked IRQs,
// runs the Exc/ExcAck/ERet handshake and holds EStatus for the handler.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_IRQ     = 4,
  parameter int ESTATUS_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  exc_irq_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             exc_q, exc_d;
  logic [3:0]       es_q, es_d;
  logic [2:0]       sel_q, sel_d;
  logic             sel_irq_q, sel_irq_d;
  logic             in_h_q, in_h_d;
  logic [N_IRQ-1:0] iack_q, iack_d;

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] elig;
  logic             req_any;
  logic [2:0]       pick;
  logic [3:0]       new_code;

  irq_pending #(.N_IRQ(N_IRQ)) u_pending (
    .clk     (clk),
    .reset   (reset),
    .ext_irq (bus.ExtIRQ),
    .clr     (clr),
    .pending (pending)
  );

  always_comb begin
    elig    = pending & bus.IrqMask;
    req_any = bus.NotAnInstr | (|elig);
    // Scan downward so the lowest eligible index is the one left in pick.
    pick    = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) pick = i[2:0];
    end
    new_code = bus.NotAnInstr ? ES_INVALID : irq_code(pick);

    state_d   = state_q;
    exc_d     = exc_q;
    es_d      = es_q;
    sel_d     = sel_q;
    sel_irq_d = sel_irq_q;
    in_h_d    = in_h_q;
    iack_d    = '0;
    clr       = '0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d   = REQ;
          exc_d     = 1'b1;
          es_d      = new_code;
          sel_d     = pick;
          sel_irq_d = ~bus.NotAnInstr;
        end
      end
      REQ: begin
        if (bus.ExcAck) begin
          state_d = HANDLER;
          exc_d   = 1'b0;
          in_h_d  = 1'b1;
          if (sel_irq_q) iack_d = N_IRQ'(1) << sel_q;
          clr = iack_d;
        end
      end
      HANDLER: begin
        // A fault inside the handler escalates ahead of any return.
        if (bus.NotAnInstr) begin
          state_d   = REQ;
          exc_d     = 1'b1;
          in_h_d    = 1'b0;
          es_d      = ES_DBLFAULT;
          sel_irq_d = 1'b0;
        end else if (bus.ERet) begin
          state_d = IDLE;
          in_h_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        exc_d   = 1'b0;
        in_h_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      exc_q     <= 1'b0;
      es_q      <= ES_NONE;
      sel_q     <= 3'd0;
      sel_irq_q <= 1'b0;
      in_h_q    <= 1'b0;
      iack_q    <= '0;
    end else begin
      state_q   <= state_d;
      exc_q     <= exc_d;
      es_q      <= es_d;
      sel_q     <= sel_d;
      sel_irq_q <= sel_irq_d;
      in_h_q    <= in_h_d;
      iack_q    <= iack_d;
    end
  end

  assign bus.Exc       = exc_q;
  assign bus.EStatus   = ESTATUS_W'(es_q);
  assign bus.ExtIAck   = iack_q;
  assign bus.InHandler = in_h_q;
  assign bus.Pending   = pending;
  assign bus.state_dbg = state_q;

endmodule
